// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-prefixed byte stream from a host
// and writes the resulting 16-bit words into main memory while holding the CPU.
module program_loader #(
    parameter int unsigned MEM_DEPTH = 4096,
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        rx_ready,
    output logic [15:0] mem_address,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    output logic        cpu_hold,
    output logic        done,
    output logic        load_error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN_HI  = 3'd1,
        LEN_LO  = 3'd2,
        DATA_HI = 3'd3,
        DATA_LO = 3'd4,
        WRITE   = 3'd5,
        DONE    = 3'd6,
        ERROR   = 3'd7
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        accept_s;
    logic [15:0] len_s;
    logic [7:0]  len_hi_r;
    logic [15:0] len_r;
    logic [7:0]  data_hi_r;
    logic [15:0] mem_address_r;
    logic [15:0] mem_data_r;
    logic [15:0] words_loaded_r;
    logic        rx_ready_r;
    logic        mem_wren_r;
    logic        cpu_hold_r;
    logic        done_r;
    logic        load_error_r;

    function automatic logic is_receive(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) || (s == DATA_LO);
    endfunction

    function automatic logic is_hold(input state_t s);
        return is_receive(s) || (s == WRITE);
    endfunction

    assign accept_s = rx_valid && rx_ready_r;
    assign len_s    = {len_hi_r, rx_byte};

    // Next-state logic for the load sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = LEN_HI;
                else       next_state_s = IDLE;
            end
            LEN_HI: begin
                if (accept_s) next_state_s = LEN_LO;
                else          next_state_s = LEN_HI;
            end
            LEN_LO: begin
                if (!accept_s)                            next_state_s = LEN_LO;
                else if (len_s == 16'h0000)               next_state_s = DONE;
                else if ({16'h0000, len_s} > MEM_DEPTH)   next_state_s = ERROR;
                else                                      next_state_s = DATA_HI;
            end
            DATA_HI: begin
                if (accept_s) next_state_s = DATA_LO;
                else          next_state_s = DATA_HI;
            end
            DATA_LO: begin
                if (accept_s) next_state_s = WRITE;
                else          next_state_s = DATA_LO;
            end
            WRITE: begin
                if ((words_loaded_r + 16'd1) == len_r) next_state_s = DONE;
                else                                   next_state_s = DATA_HI;
            end
            DONE:    next_state_s = IDLE;
            ERROR:   next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // State register; status flags are registered from the upcoming state so they align with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            rx_ready_r   <= 1'b0;
            mem_wren_r   <= 1'b0;
            cpu_hold_r   <= 1'b0;
            done_r       <= 1'b0;
            load_error_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            rx_ready_r   <= is_receive(next_state_s);
            mem_wren_r   <= (next_state_s == WRITE);
            cpu_hold_r   <= is_hold(next_state_s);
            done_r       <= (next_state_s == DONE);
            load_error_r <= (next_state_s == ERROR);
        end
    end

    // Byte assembly, write-port capture and word counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_hi_r       <= 8'h00;
            len_r          <= 16'h0000;
            data_hi_r      <= 8'h00;
            mem_address_r  <= 16'h0000;
            mem_data_r     <= 16'h0000;
            words_loaded_r <= 16'h0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) words_loaded_r <= 16'h0000;
                end
                LEN_HI: begin
                    if (accept_s) len_hi_r <= rx_byte;
                end
                LEN_LO: begin
                    if (accept_s) len_r <= len_s;
                end
                DATA_HI: begin
                    if (accept_s) data_hi_r <= rx_byte;
                end
                DATA_LO: begin
                    // Capture here so address/data are stable for the whole WRITE cycle and held afterwards.
                    if (accept_s) begin
                        mem_data_r    <= {data_hi_r, rx_byte};
                        mem_address_r <= BASE_ADDR + words_loaded_r;
                    end
                end
                WRITE: begin
                    words_loaded_r <= words_loaded_r + 16'd1;
                end
                default: begin
                end
            endcase
        end
    end

    assign rx_ready     = rx_ready_r;
    assign mem_address  = mem_address_r;
    assign mem_data     = mem_data_r;
    assign mem_wren     = mem_wren_r;
    assign cpu_hold     = cpu_hold_r;
    assign done         = done_r;
    assign load_error   = load_error_r;
    assign words_loaded = words_loaded_r;

endmodule
